// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - SECDED(16,11) widths, data-position table and receiver FSM states
package hamming_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;

  // Hamming position of data bit d[i]; positions 1,2,4,8 carry parity, index 0 holds p0
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } state_t;

endpackage

// File: rtl/hamming_secded_check.sv
// rtl/hamming_secded_check.sv - combinational SECDED syndrome, correction and data extraction
module hamming_secded_check
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [3:0]        syndrome,
  output logic              err_corr,
  output logic              err_uncorr
);

  logic              parity;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    syndrome = '0;
    for (int k = 1; k < CODE_W; k++) begin
      if (code[k]) syndrome = syndrome ^ 4'(k);
    end
  end

  assign parity = ^code;

  // Odd overall parity means a single error; syndrome 0 then points at p0 itself
  always_comb begin
    fixed = code;
    if (parity && (syndrome != 4'd0)) fixed[syndrome] = ~code[syndrome];
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < DATA_W; i++) data[i] = fixed[DATA_POS[i]];
  end

  assign err_corr   = parity;
  assign err_uncorr = !parity && (syndrome != 4'd0);

endmodule

// File: rtl/hamming_secded_rx.sv
// rtl/hamming_secded_rx.sv - serial SECDED(16,11) frame receiver with saturating error counters
module hamming_secded_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              bit_sof,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [3:0]        syndrome,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] shreg_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              start;
  logic              accept_last;

  logic [DATA_W-1:0] chk_data;
  logic [3:0]        chk_syndrome;
  logic              chk_corr;
  logic              chk_uncorr;

  assign start       = bit_valid && bit_sof;
  assign accept_last = (state == SHIFT) && bit_valid && !bit_sof && (bit_cnt == 4'd15);

  // Bits shift in from the top, so after 16 bits position 1 sits at [0] and p0 at [15]
  assign shreg_nxt = {bit_in, shreg[CODE_W-1:1]};
  assign code_nxt  = {shreg_nxt[CODE_W-2:0], shreg_nxt[CODE_W-1]};

  hamming_secded_check u_check (
    .code       (code_nxt),
    .data       (chk_data),
    .syndrome   (chk_syndrome),
    .err_corr   (chk_corr),
    .err_uncorr (chk_uncorr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DECODE: state_nxt = start ? SHIFT : IDLE;
      SHIFT: begin
        if (start)            state_nxt = SHIFT;
        else if (accept_last) state_nxt = DECODE;
      end
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dout_valid = (state == DECODE);
  end

  // sof always restarts the frame, whichever state it arrives in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= 4'd0;
    end else if (start) begin
      shreg   <= {bit_in, {(CODE_W-1){1'b0}}};
      bit_cnt <= 4'd1;
    end else if ((state == SHIFT) && bit_valid) begin
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      syndrome   <= 4'd0;
    end else if (accept_last) begin
      dout       <= chk_data;
      err_corr   <= chk_corr;
      err_uncorr <= chk_uncorr;
      syndrome   <= chk_syndrome;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (dout_valid) begin
      if (err_corr && (corr_cnt != {CNT_W{1'b1}}))     corr_cnt   <= corr_cnt + 1'b1;
      if (err_uncorr && (uncorr_cnt != {CNT_W{1'b1}})) uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_rx.sv
// tb/tb_hamming_secded_rx.sv - scoreboard bench for hamming_secded_rx with directed frames
module tb_hamming_secded_rx;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_sof;
  logic [10:0]      dout;
  logic             dout_valid;
  logic             err_corr;
  logic             err_uncorr;
  logic [3:0]       syndrome;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  typedef struct {
    logic [10:0] dout;
    logic        corr;
    logic        uncorr;
    logic [3:0]  syn;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_pulse  = 0;
  int   n_pushed = 0;
  exp_t last_exp;

  hamming_secded_rx #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_sof    (bit_sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .syndrome   (syndrome),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      n_pulse++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_exp = e;
        chk("dout", 32'(dout), 32'(e.dout));
        chk("err_corr", 32'(err_corr), 32'(e.corr));
        chk("err_uncorr", 32'(err_uncorr), 32'(e.uncorr));
        chk("syndrome", 32'(syndrome), 32'(e.syn));
      end
    end
  end

  // code[k] is Hamming position k for k=1..15, code[0] is p0
  task automatic send_bits(input logic [15:0] code, input int nbits, input logic sof_first);
    for (int k = 1; k <= nbits; k++) begin
      bit_valid = 1'b1;
      bit_sof   = sof_first && (k == 1);
      bit_in    = (k < 16) ? code[k] : code[0];
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] code, input logic [10:0] d,
                            input logic c, input logic u, input logic [3:0] s);
    exp_t e;
    e.dout = d; e.corr = c; e.uncorr = u; e.syn = s;
    sb.push_back(e);
    n_pushed++;
    send_bits(code, 16, 1'b1);
    chk("valid_latency", 32'(dout_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
    bit_in    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; bit_sof = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_flags", 32'({err_corr, err_uncorr}), 32'd0);
    chk("rst_syn", 32'(syndrome), 32'd0);
    chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    send_frame(16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
    idle(1);
    chk("pulse_one_cycle", 32'(dout_valid), 32'd0);
    idle(2);
    send_frame(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
    idle(3);
    send_frame(16'h0020, 11'h000, 1'b1, 1'b0, 4'd5);
    idle(3);
    chk("corr_cnt_1", 32'(corr_cnt), 32'd1);
    send_frame(16'h0028, 11'h003, 1'b0, 1'b1, 4'd6);
    idle(3);
    chk("uncorr_cnt_1", 32'(uncorr_cnt), 32'd1);

    send_frame(16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
    send_frame(16'h020F, 11'h001, 1'b1, 1'b0, 4'd9);
    send_frame(16'h000E, 11'h001, 1'b1, 1'b0, 4'd0);
    send_frame(16'h020E, 11'h011, 1'b0, 1'b1, 4'd9);
    idle(3);
    chk("corr_cnt_3", 32'(corr_cnt), 32'd3);
    chk("uncorr_cnt_2", 32'(uncorr_cnt), 32'd2);
    chk("hold_dout", 32'(dout), 32'h011);
    chk("hold_syn", 32'(syndrome), 32'd9);

    // restart mid-frame, then a full frame without sof while idle
    send_bits(16'h5555, 7, 1'b1);
    send_frame(16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
    idle(2);
    send_bits(16'h0020, 16, 1'b0);
    idle(3);

    send_bits(16'h0020, 10, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
    rst_n = 1'b1;
    send_bits(16'h0020, 6, 1'b0);
    idle(3);
    send_frame(16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
    idle(3);
    chk("post_rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);

    for (int i = 0; i < 8; i++) send_frame(16'h000E, 11'h001, 1'b1, 1'b0, 4'd0);
    idle(3);
    chk("corr_cnt_sat", 32'(corr_cnt), 32'd7);
    chk("uncorr_cnt_zero", 32'(uncorr_cnt), 32'd0);

    chk("pulse_count", 32'(n_pulse), 32'(n_pushed));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_secded_rx.md
HAMMING_SECDED_RX -- requirements
Module: hamming_secded_rx

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, width of the saturating error counters.
REQ-002 The block SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port bit_in  input  1  serial codeword bit.
REQ-005 The block SHALL have port bit_valid  input  1  bit_in is sampled on clk edges where bit_valid=1.
REQ-006 The block SHALL have port bit_sof  input  1  qualified by bit_valid, marks the first bit of a frame.
REQ-007 The block SHALL have port dout  output  11  decoded data word.
REQ-008 The block SHALL have port dout_valid  output  1  one-cycle pulse, dout and flags valid.
REQ-009 The block SHALL have port err_corr  output  1  single error corrected, valid with dout_valid.
REQ-010 The block SHALL have port err_uncorr  output  1  double error detected, valid with dout_valid.
REQ-011 The block SHALL have port syndrome  output  4  Hamming syndrome of the last frame.
REQ-012 The block SHALL have port corr_cnt  output  CNT_W  saturating count of err_corr frames.
REQ-013 The block SHALL have port uncorr_cnt  output  CNT_W  saturating count of err_uncorr frames.

Function
REQ-014 Frame SHALL be 16 bits, SECDED(16,11): Hamming positions 1..15 sent first (position 1 first), then overall parity bit p0 last.
REQ-015 Data bit d[i], i=0..10, SHALL map to positions 3,5,6,7,9,10,11,12,13,14,15 ascending; parity at 1,2,4,8; p0 gives even parity over all 16 bits.
REQ-016 FSM states SHALL be IDLE, SHIFT, DECODE: IDLE->SHIFT on bit_valid&bit_sof; SHIFT->DECODE on acceptance of the 16th bit; DECODE->IDLE unconditionally next cycle.
REQ-017 In IDLE, bit_valid without bit_sof SHALL be ignored.
REQ-018 bit_valid&bit_sof in SHIFT SHALL discard the partial frame and restart with the current bit as position 1; no dout_valid for the discarded frame.
REQ-019 bit_valid in DECODE SHALL be handled as in IDLE, so back-to-back frames lose no bits.
REQ-020 syndrome SHALL be the XOR of the position indices of all set bits in positions 1..15; P SHALL be the XOR of all 16 bits.
REQ-021 If s=0,P=0, dout SHALL be the raw data with both flags 0.
REQ-022 If P=1, the block SHALL invert position s when s!=0, set err_corr=1 and err_uncorr=0.
REQ-023 If s!=0,P=0, dout SHALL be the uncorrected data, err_uncorr=1, err_corr=0.
REQ-024 dout_valid SHALL pulse for exactly one cycle, the cycle after the 16th bit is accepted.
REQ-025 dout, flags and syndrome SHALL hold until the next dout_valid.
REQ-026 corr_cnt and uncorr_cnt SHALL increment on dout_valid with the respective flag and SHALL hold at 2^CNT_W-1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, bit counter 0, shift register 0, dout=0, dout_valid=0, err_corr=0, err_uncorr=0, syndrome=0, both counters 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL require bit_sof.

Structure
REQ-029 The shared package hamming_pkg SHALL hold DATA_W=11, CODE_W=16, the data-position table, and the FSM state typedef.
REQ-030 Syndrome calculation and correction SHALL be one combinational sub-module, hamming_secded_check (16-bit codeword in; data, s, flags out).

Verification
REQ-031 All-zero frame -> dout=11'h000, flags 0, syndrome 0, dout_valid one cycle after bit 16.
REQ-032 Sixteen ones -> dout=11'h7FF, flags 0.
REQ-033 All-zero frame with position 5 flipped -> dout=11'h000, err_corr=1, syndrome=5, corr_cnt=1.
REQ-034 All-zero frame with positions 3 and 5 flipped -> err_uncorr=1, syndrome=6, dout=11'h003, uncorr_cnt=1.
REQ-035 bit_sof after 7 bits, then a clean 16-bit all-ones frame -> exactly one dout_valid with dout=11'h7FF.
REQ-036 rst_n pulsed after 10 bits, then a clean all-zero frame -> no pulse before the new frame, dout=11'h000, counters 0.
